pwm_table_sequencer: RTL and testbench

- Controller in front of the PWM signal-table memory: owns the memory address, write-enable and data-in, and shares the single port between host table writes and sample playback.
- Generates the sample-rate tick internally; steps the read index 0..Length-1 in continuous or one-shot mode.
- Registers each fetched sample as the duty value fed to the comparator.

---
 rtl/pwm_table_sequencer_pkg.sv | 23 ++
 rtl/pwm_tick_gen.sv | 38 +++
 rtl/pwm_table_sequencer.sv | 170 +++++++++++++++++
 tb/tb_pwm_table_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_table_sequencer_pkg.sv
// Shared types and default sizing for the PWM signal-table sequencer.
package pwm_table_sequencer_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ADDR_W   = 7;
  localparam int DEF_DEPTH    = 100;
  localparam int DEF_PRESCALE = 500000;

  // One bit of headroom over the reload value keeps the counter width safe for any PRESCALE.
  function automatic int div_width(input int prescale);
    return $clog2(prescale) + 1;
  endfunction

  localparam int DEF_DIV_W = div_width(DEF_PRESCALE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN_WAIT,
    ST_RUN_READ,
    ST_RUN_LATCH
  } state_e;

endpackage

// File: rtl/pwm_tick_gen.sv
// Sample-rate prescaler: loadable down-counter that ticks once every PRESCALE enabled cycles.
module pwm_tick_gen #(
  parameter int DIV_W    = 20,
  parameter int PRESCALE = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic tick
);

  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(PRESCALE - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (enable) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_table_sequencer.sv
// Single-port table controller: arbitrates host writes against paced sample playback and
// registers each fetched sample as the PWM duty value.
module pwm_table_sequencer
  import pwm_table_sequencer_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int DIV_W    = div_width(PRESCALE)
) (
  input  logic              ClkOsc,
  input  logic              Rst,
  input  logic              Cfg_Start,
  input  logic              Cfg_Stop,
  input  logic              Cfg_OneShot,
  input  logic [ADDR_W-1:0] Cfg_Length,
  input  logic              Wr_Valid,
  output logic              Wr_Ready,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [DATA_W-1:0] Wr_Data,
  output logic              Wr_Err,
  output logic              Mem_WR,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_DataIn,
  input  logic [DATA_W-1:0] Mem_DataOut,
  output logic [DATA_W-1:0] Duty,
  output logic              Duty_Valid,
  output logic              Busy,
  output logic              Done
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              one_shot_q, one_shot_d;
  logic [DATA_W-1:0] duty_q, duty_d;
  logic              duty_valid_q, duty_valid_d;
  logic              done_q, done_d;
  logic              wr_err_q, wr_err_d;

  logic            tick;
  logic            tick_load;
  logic            running;
  logic            wr_accept;
  logic            addr_ok;
  logic            last_idx;
  logic [ADDR_W:0] cfg_len_ext;

  assign running     = (state_q != ST_IDLE);
  assign cfg_len_ext = {1'b0, Cfg_Length};
  assign last_idx    = ({1'b0, idx_q} == (len_q - 1'b1));
  assign addr_ok     = ({1'b0, Wr_Addr} < DEPTH_V);

  pwm_tick_gen #(
    .DIV_W   (DIV_W),
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk   (ClkOsc),
    .rst_n (Rst),
    .load  (tick_load),
    .enable(running),
    .tick  (tick)
  );

  // Playback owns the port in READ/LATCH and in the tick cycle; reset blocks writes outright.
  always_comb begin
    Wr_Ready = 1'b0;
    unique case (state_q)
      ST_IDLE:     Wr_Ready = 1'b1;
      ST_RUN_WAIT: Wr_Ready = !tick;
      default:     Wr_Ready = 1'b0;
    endcase
    Wr_Ready = Wr_Ready && Rst;
  end

  assign wr_accept  = Wr_Valid && Wr_Ready;
  assign Mem_WR     = wr_accept && addr_ok;
  assign Mem_Addr   = wr_accept ? Wr_Addr : idx_q;
  assign Mem_DataIn = Wr_Data;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    one_shot_d   = one_shot_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    done_d       = 1'b0;
    wr_err_d     = wr_accept && !addr_ok;
    tick_load    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (Cfg_Start && !Cfg_Stop) begin
          one_shot_d = Cfg_OneShot;
          len_d      = (cfg_len_ext == '0 || cfg_len_ext > DEPTH_V) ? DEPTH_V : cfg_len_ext;
          idx_d      = '0;
          tick_load  = 1'b1;
          state_d    = ST_RUN_READ;
        end
      end
      ST_RUN_READ: begin
        state_d = ST_RUN_LATCH;
      end
      ST_RUN_LATCH: begin
        duty_d       = Mem_DataOut;
        duty_valid_d = 1'b1;
        if (last_idx) begin
          idx_d = '0;
          if (one_shot_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN_WAIT;
          end
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_RUN_WAIT;
        end
      end
      ST_RUN_WAIT: begin
        if (tick) begin
          state_d = ST_RUN_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Stop overrides whatever the running state decided, including a pending latch.
    if (Cfg_Stop && running) begin
      state_d      = ST_IDLE;
      idx_d        = '0;
      duty_d       = '0;
      duty_valid_d = 1'b1;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge ClkOsc or negedge Rst) begin
    if (!Rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      one_shot_q   <= 1'b0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      done_q       <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      one_shot_q   <= one_shot_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      done_q       <= done_d;
      wr_err_q     <= wr_err_d;
    end
  end

  assign Duty       = duty_q;
  assign Duty_Valid = duty_valid_q;
  assign Done       = done_q;
  assign Wr_Err     = wr_err_q;
  assign Busy       = running;

endmodule

// File: tb/tb_pwm_table_sequencer.sv
// Directed bench for pwm_table_sequencer with PRESCALE=4, DEPTH=8 and a behavioural table RAM.
module tb_pwm_table_sequencer;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 4;
  localparam int DEPTH    = 8;
  localparam int PRESCALE = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, stop, one_shot;
  logic [ADDR_W-1:0] length;
  logic              wr_valid, wr_ready, wr_err;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in, mem_data_out;
  logic [DATA_W-1:0] duty;
  logic              duty_valid, busy, done;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] tb_mem [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  // Synchronous-read table memory: data valid the cycle after the address.
  always @(posedge clk) begin
    if (mem_wr) tb_mem[mem_addr] <= mem_data_in;
    mem_data_out <= tb_mem[mem_addr];
  end

  pwm_table_sequencer #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .PRESCALE(PRESCALE)
  ) dut (
    .ClkOsc     (clk),
    .Rst        (rst_n),
    .Cfg_Start  (start),
    .Cfg_Stop   (stop),
    .Cfg_OneShot(one_shot),
    .Cfg_Length (length),
    .Wr_Valid   (wr_valid),
    .Wr_Ready   (wr_ready),
    .Wr_Addr    (wr_addr),
    .Wr_Data    (wr_data),
    .Wr_Err     (wr_err),
    .Mem_WR     (mem_wr),
    .Mem_Addr   (mem_addr),
    .Mem_DataIn (mem_data_in),
    .Mem_DataOut(mem_data_out),
    .Duty       (duty),
    .Duty_Valid (duty_valid),
    .Busy       (busy),
    .Done       (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] exp_duty;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; one_shot = 1'b0; length = '0;
    wr_valid = 1'b1; wr_addr = '0; wr_data = '0;

    // Reset state
    repeat (2) step();
    check("rst_busy", busy, 0);
    check("rst_duty", duty, 0);
    check("rst_duty_valid", duty_valid, 0);
    check("rst_done", done, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_mem_wr", mem_wr, 0);
    wr_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Fill table 0..7 with 10..17 back-to-back
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = ADDR_W'(i); wr_data = 8'h10 + DATA_W'(i);
      #1;
      check("fill_ready", wr_ready, 1);
      check("fill_mem_wr", mem_wr, 1);
      check("fill_addr", mem_addr, i);
      step();
      check("fill_err", wr_err, 0);
    end
    wr_valid = 1'b0;
    step();

    // Continuous, Length=3, Start in cycle S
    length = 3; one_shot = 1'b0; start = 1'b1;
    step(); start = 1'b0; #1;                       // S+1 RUN_READ
    check("cont_busy_read", busy, 1);
    check("cont_addr_read", mem_addr, 0);
    check("cont_ready_read", wr_ready, 0);
    step(); step();                                 // S+3
    check("cont_duty0", duty, 8'h10);
    check("cont_valid0", duty_valid, 1);
    check("cont_done0", done, 0);
    step();                                         // S+4 tick cycle
    start = 1'b1; one_shot = 1'b1; length = 1; #1;  // restart attempt while running
    check("cont_tick_ready", wr_ready, 0);
    check("cont_valid_gap", duty_valid, 0);
    step(); start = 1'b0; one_shot = 1'b0; length = 3; // S+5
    step(); step();                                 // S+7
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: exp_duty = 8'h11;
        1: exp_duty = 8'h12;
        2: exp_duty = 8'h10;
        default: exp_duty = 8'h11;
      endcase
      check("cont_duty", duty, exp_duty);
      check("cont_valid", duty_valid, 1);
      check("cont_done", done, 0);
      check("cont_busy", busy, 1);
      if (k < 3) repeat (4) step();
    end                                             // now S+19
    step(); step();                                 // S+21 RUN_READ idx 2
    check("stop_read_addr", mem_addr, 2);
    stop = 1'b1;
    step(); stop = 1'b0;                            // S+22
    check("stop_read_busy", busy, 0);
    check("stop_read_duty", duty, 0);
    check("stop_read_valid", duty_valid, 1);
    check("stop_read_done", done, 0);
    step();
    check("stop_read_valid_end", duty_valid, 0);
    check("stop_read_duty_hold", duty, 0);

    // One-shot, Length=0 -> all 8 entries
    one_shot = 1'b1; length = 0; start = 1'b1;
    step(); start = 1'b0; one_shot = 1'b0;
    step(); step();                                 // S+3
    check("os_duty0", duty, 8'h10);
    check("os_valid0", duty_valid, 1);
    check("os_done0", done, 0);
    for (int k = 1; k < 8; k++) begin
      step(); step(); step();                       // RUN_LATCH
      check("os_busy_latch", busy, 1);
      step();
      check("os_duty", duty, 8'h10 + k);
      check("os_valid", duty_valid, 1);
      check("os_done", done, (k == 7) ? 1 : 0);
      check("os_busy", busy, (k == 7) ? 0 : 1);
    end
    repeat (6) step();
    check("os_duty_hold", duty, 8'h17);
    check("os_busy_idle", busy, 0);
    check("os_valid_idle", duty_valid, 0);
    check("os_done_idle", done, 0);

    // Continuous with Wr_Valid held: addr 2 <= AA
    length = 3; start = 1'b1;
    step(); start = 1'b0;                           // S+1
    wr_valid = 1'b1; wr_addr = 2; wr_data = 8'hAA;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) step();
      #1;
      check("wrun_ready", wr_ready, (c % 4 == 3) ? 1 : 0);
      check("wrun_mem_wr", mem_wr, (c % 4 == 3) ? 1 : 0);
      if (c % 4 == 3) begin
        case (c)
          3: exp_duty = 8'h10;
          7: exp_duty = 8'h11;
          default: exp_duty = 8'hAA;
        endcase
        check("wrun_duty", duty, exp_duty);
        check("wrun_addr", mem_addr, 2);
      end
    end
    wr_valid = 1'b0;                                // S+12
    repeat (7) step();                              // S+19
    check("wrun_duty_p2_1", duty, 8'h11);
    repeat (4) step();                              // S+23
    check("wrun_duty_p2_2", duty, 8'hAA);
    check("wrun_valid_p2_2", duty_valid, 1);
    stop = 1'b1;
    step(); stop = 1'b0;
    check("wrun_stop_busy", busy, 0);
    check("wrun_stop_duty", duty, 0);
    check("wrun_stop_valid", duty_valid, 1);

    // Out-of-range write
    step();
    wr_valid = 1'b1; wr_addr = 9; wr_data = 8'h55; #1;
    check("oor_ready", wr_ready, 1);
    check("oor_mem_wr", mem_wr, 0);
    step(); wr_valid = 1'b0;
    check("oor_err", wr_err, 1);
    step();
    check("oor_err_once", wr_err, 0);

    // Start and Stop together in IDLE
    start = 1'b1; stop = 1'b1;
    step(); start = 1'b0; stop = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_valid", duty_valid, 0);
    step();
    check("ss_busy2", busy, 0);

    // Stop during RUN_LATCH discards the in-flight sample
    length = 5; one_shot = 1'b1; start = 1'b1;
    step(); start = 1'b0; one_shot = 1'b0;          // S+1
    step();                                         // S+2 RUN_LATCH
    check("sl_busy", busy, 1);
    stop = 1'b1;
    step(); stop = 1'b0;                            // S+3
    check("sl_busy_after", busy, 0);
    check("sl_duty", duty, 0);
    check("sl_valid", duty_valid, 1);
    check("sl_done", done, 0);
    step();
    check("sl_valid_end", duty_valid, 0);
    check("sl_duty_end", duty, 0);

    // Async reset mid-run
    length = 3; one_shot = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    step(); step();                                 // S+3
    check("ar_pre_duty", duty, 8'h10);
    check("ar_pre_valid", duty_valid, 1);
    wr_valid = 1'b1; wr_addr = 3; rst_n = 1'b0; #1;
    check("ar_busy", busy, 0);
    check("ar_duty", duty, 0);
    check("ar_valid", duty_valid, 0);
    check("ar_done", done, 0);
    check("ar_wr_err", wr_err, 0);
    check("ar_wr_ready", wr_ready, 0);
    check("ar_mem_wr", mem_wr, 0);
    check("ar_mem_addr", mem_addr, 0);
    step(); rst_n = 1'b1; wr_valid = 1'b0;
    step();

    // Table survives reset: one-shot Length=3 plays 10, 11, AA
    length = 3; one_shot = 1'b1; start = 1'b1;
    step(); start = 1'b0; one_shot = 1'b0;
    step(); step();
    check("post_duty0", duty, 8'h10);
    repeat (4) step();
    check("post_duty1", duty, 8'h11);
    repeat (4) step();
    check("post_duty2", duty, 8'hAA);
    check("post_done", done, 1);
    check("post_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
